// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one external 32-bit adder among NUM_REQ clients.
// Define ADDER_ARB_STATS_EN to add the stat_ops / stat_wait counters.
module adder_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [32*NUM_REQ-1:0]  req_a,
    input  logic [32*NUM_REQ-1:0]  req_b,
    input  logic [NUM_REQ-1:0]     req_cin,
    output logic [31:0]            add_a,
    output logic [31:0]            add_b,
    output logic                   add_cin,
    input  logic [39:0]            add_sum,
    input  logic                   add_cout,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [39:0]            rsp_sum,
    output logic                   rsp_err
`ifdef ADDER_ARB_STATS_EN
    ,
    output logic [31:0]            stat_ops,
    output logic [31:0]            stat_wait
`endif
);

    localparam int OPW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] last_q, last_d;
    logic [ID_W-1:0] gnt_q, gnt_d;
    logic [31:0]     a_q, a_d;
    logic [31:0]     b_q, b_d;
    logic            cin_q, cin_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [39:0]     rsp_sum_q, rsp_sum_d;
    logic            rsp_err_q, rsp_err_d;

    logic            gnt_found_s;
    logic [ID_W-1:0] gnt_idx_s;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        gnt_found_s = 1'b0;
        gnt_idx_s   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (int'(last_q) + k) % NUM_REQ;
            if (!gnt_found_s && req_valid[idx]) begin
                gnt_found_s = 1'b1;
                gnt_idx_s   = ID_W'(idx);
            end else begin
                gnt_idx_s   = gnt_idx_s;
            end
        end
    end

    // Accept is offered only while idle and out of reset.
    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && !rst && gnt_found_s) begin
            req_ready = NUM_REQ'(1) << gnt_idx_s;
        end else begin
            req_ready = '0;
        end
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        a_d         = a_q;
        b_d         = b_q;
        cin_d       = cin_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (gnt_found_s) begin
                    a_d     = req_a[int'(gnt_idx_s)*OPW +: OPW];
                    b_d     = req_b[int'(gnt_idx_s)*OPW +: OPW];
                    cin_d   = req_cin[gnt_idx_s];
                    gnt_d   = gnt_idx_s;
                    last_d  = gnt_idx_s;
                    state_d = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                // Upper bits must be zero and bit 32 must agree with the carry.
                rsp_sum_d   = add_sum;
                rsp_id_d    = gnt_q;
                rsp_err_d   = (add_sum[39:33] != 7'd0) || (add_sum[32] != add_cout);
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d     = RESP;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= ID_W'(NUM_REQ - 1);
            gnt_q       <= '0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            cin_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= 40'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cin_q       <= cin_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign add_a     = a_q;
    assign add_b     = b_q;
    assign add_cin   = cin_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_err   = rsp_err_q;

`ifdef ADDER_ARB_STATS_EN
    logic [31:0] stat_ops_q, stat_wait_q;

    // Completed responses and cycles where a request is pending but not offered.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops_q  <= 32'd0;
            stat_wait_q <= 32'd0;
        end else begin
            if (state_q == RESP && rsp_ready) begin
                stat_ops_q <= stat_ops_q + 32'd1;
            end else begin
                stat_ops_q <= stat_ops_q;
            end
            if ((|req_valid) && !(|req_ready)) begin
                stat_wait_q <= stat_wait_q + 32'd1;
            end else begin
                stat_wait_q <= stat_wait_q;
            end
        end
    end

    assign stat_ops  = stat_ops_q;
    assign stat_wait = stat_wait_q;
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed scoreboard bench for adder_share_arbiter with a behavioural adder
// that can inject sum-bit and carry faults.
module tb_adder_share_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a, req_b;
    logic [3:0]   req_cin;
    logic [31:0]  add_a, add_b;
    logic         add_cin;
    logic [39:0]  add_sum;
    logic         add_cout;
    logic         rsp_valid, rsp_ready;
    logic [1:0]   rsp_id;
    logic [39:0]  rsp_sum;
    logic         rsp_err;
`ifdef ADDER_ARB_STATS_EN
    logic [31:0]  stat_ops, stat_wait;
`endif

    logic         fault_sum = 1'b0;
    logic         fault_cout = 1'b0;
    logic [32:0]  s33;
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    logic [42:0]  sb[$];

    adder_share_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_err(rsp_err)
`ifdef ADDER_ARB_STATS_EN
        , .stat_ops(stat_ops), .stat_wait(stat_wait)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign s33      = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};
    assign add_sum  = {7'd0, s33} ^ (fault_sum ? 40'h08_0000_0000 : 40'h0);
    assign add_cout = s33[32] ^ fault_cout;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic c);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
        req_cin[i]        = c;
    endtask

    task automatic wait_grant(input logic [3:0] exp, input string name, output int n);
        n = 0;
        @(negedge clk);
        while (req_ready == 4'd0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, req_ready, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    // Monitor: every response handshake is compared against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", {rsp_err, rsp_id, rsp_sum}, 43'd0 - 43'd1);
                end else begin
                    chk("rsp", {rsp_err, rsp_id, rsp_sum}, sb.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int last_g;
        logic [39:0] rr_sum [4];
        rr_sum[0] = 40'h01_0000_0000;
        rr_sum[1] = 40'h01_1000_0003;
        rr_sum[2] = 40'h01_2000_0004;
        rr_sum[3] = 40'h01_3000_0007;

        // Reset and a single operation.
        rst = 1'b1; rsp_ready = 1'b1;
        req_a = '0; req_b = '0; req_cin = '0;
        set_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        req_valid = 4'b0001;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_rsp", {rsp_valid, rsp_err, rsp_id, rsp_sum}, 64'd0);
        chk("reset_add", {add_cin, add_a, add_b}, 64'd0);
        chk("reset_ready", req_ready, 4'b0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_grant(4'b0001, "g_single", n);
        sb.push_back({1'b0, 2'd0, 40'h01_0000_0000});
        req_valid = 4'b0000;
        @(negedge clk);
        chk("add_drive", {add_cin, add_a, add_b}, {1'b0, 32'hFFFF_FFFF, 32'h1});
        chk("lat_exec", rsp_valid, 1'b0);
        @(negedge clk);
        chk("lat_resp", rsp_valid, 1'b1);
        @(posedge clk);
        #1;
`ifdef ADDER_ARB_STATS_EN
        chk("stat_ops_1", stat_ops, 32'd1);
`endif

        // All four requesters continuously valid from reset.
        rst = 1'b1;
        set_op(0, 32'h1000_0000, 32'hF000_0000, 1'b0);
        set_op(1, 32'h2000_0001, 32'hF000_0001, 1'b1);
        set_op(2, 32'h3000_0002, 32'hF000_0002, 1'b0);
        set_op(3, 32'h4000_0003, 32'hF000_0003, 1'b1);
        req_valid = 4'b1111;
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_g = 0;
        for (int k = 0; k < 5; k++) begin
            wait_grant(4'b0001 << (k % 4), "g_rr", n);
            if (k > 0) chk("rr_gap", cyc - last_g, 3);
            last_g = cyc;
            sb.push_back({1'b0, 2'(k % 4), rr_sum[k % 4]});
            if (k == 4) req_valid = 4'b0000;
        end
        drain();

        // Backpressure on requester 1, with requester 2 waiting meanwhile.
        rsp_ready = 1'b0;
        set_op(1, 32'h0000_0007, 32'h0000_0008, 1'b0);
        req_valid = 4'b0010;
        wait_grant(4'b0010, "g_bp", n);
        sb.push_back({1'b0, 2'd1, 40'h00_0000_000F});
        set_op(2, 32'h1234_5678, 32'h1111_1111, 1'b1);
        req_valid = 4'b0100;
        @(negedge clk);
        chk("busy_exec", req_ready, 4'b0000);
        @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold", {rsp_valid, rsp_id, rsp_sum, req_ready}, {1'b1, 2'd1, 40'h0F, 4'b0000});
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        wait_grant(4'b0100, "g_req2", n);
        chk("bp_release", n, 1);
        sb.push_back({1'b0, 2'd2, 40'h00_2345_678A});
        set_op(3, 32'h8000_0000, 32'h8000_0000, 1'b1);
        req_valid = 4'b1011;
        wait_grant(4'b1000, "g_after2", n);
        sb.push_back({1'b0, 2'd3, 40'h01_0000_0001});
        req_valid = 4'b0000;
        drain();

        // Faulty adder: stray upper sum bit, then wrong carry-out.
        fault_sum = 1'b1;
        set_op(0, 32'h0000_0001, 32'h0000_0002, 1'b0);
        req_valid = 4'b0001;
        wait_grant(4'b0001, "g_fault_sum", n);
        sb.push_back({1'b1, 2'd0, 40'h08_0000_0003});
        req_valid = 4'b0000;
        drain();
        fault_sum = 1'b0;
        fault_cout = 1'b1;
        set_op(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        req_valid = 4'b0010;
        wait_grant(4'b0010, "g_fault_cout", n);
        sb.push_back({1'b1, 2'd1, 40'h01_0000_0000});
        req_valid = 4'b0000;
        drain();
        fault_cout = 1'b0;

        // Reset while in EXEC aborts the operation and restores priority to req0.
        set_op(2, 32'h0000_0100, 32'h0000_0200, 1'b0);
        req_valid = 4'b0100;
        wait_grant(4'b0100, "g_abort", n);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("abort_rsp", {rsp_valid, rsp_err, rsp_id, rsp_sum}, 64'd0);
        chk("abort_add", {add_cin, add_a, add_b}, 64'd0);
        chk("abort_ready", req_ready, 4'b0000);
`ifdef ADDER_ARB_STATS_EN
        chk("stat_ops_rst", stat_ops, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_op(0, 32'h0000_0005, 32'h0000_0006, 1'b1);
        req_valid = 4'b1111;
        wait_grant(4'b0001, "g_after_rst", n);
        sb.push_back({1'b0, 2'd0, 40'h00_0000_000C});
        req_valid = 4'b0000;
        drain();

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
